// File: rtl/decoder_pkg.sv
// Shared types and defaults for the decoder select control slice.
// Holds select width/type, parameter defaults and the select step helper.
package decoder_pkg;

  localparam int SEL_W            = 2;
  localparam int DEBOUNCE_DEFAULT = 16;
  localparam int SCAN_DIV_DEFAULT = 1024;

  typedef logic [SEL_W-1:0] sel_t;

  // Simultaneous up and down cancel out.
  function automatic sel_t sel_step(
    input sel_t s,
    input logic up,
    input logic dn
  );
    sel_t r;
    r = s;
    unique case (1'b1)
      (up & ~dn): r = s + sel_t'(1);
      (dn & ~up): r = s - sel_t'(1);
      default:    r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, debounce counter, stable level, rise pulse.
// Ports: clk, rst_n, btn_i (raw) -> rise_o (one-cycle press pulse).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    prev_d = stable_q;
    rise_d = stable_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/decoder_select_ctrl.sv
// Select control for the 2-to-4 decoder: buttons step a wrapping select.
// Ports: clk, rst_n, ena, btn_up_i, btn_down_i, en_i, scan_i -> sel_o, en_o, step_o.
// Optional autoscan prescaler built when SELECT_AUTOSCAN_EN is defined.
module decoder_select_ctrl
  import decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SCAN_DIV        = SCAN_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  input  logic             en_i,
  input  logic             scan_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             en_o,
  output logic             step_o
);

  logic up_rise;
  logic dn_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_up_i),
    .rise_o(up_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_down_i),
    .rise_o(dn_rise)
  );

  sel_t sel_q, sel_d;
  logic step_q, step_d;
  logic en_s1_q, en_s1_d;
  logic en_s2_q, en_s2_d;

`ifdef SELECT_AUTOSCAN_EN
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic          scan_s1_q, scan_s1_d;
  logic          scan_s2_q, scan_s2_d;
  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    scan_s1_d = scan_i;
    scan_s2_d = scan_s1_q;
    presc_d   = presc_q;
    sel_d     = sel_q;
    if (!scan_s2_q) begin
      presc_d = '0;
    end
    if (ena) begin
      if (scan_s2_q) begin
        // Buttons are ignored while scanning.
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          sel_d   = sel_q + sel_t'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end else begin
        sel_d = sel_step(sel_q, up_rise, dn_rise);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_s1_q <= 1'b0;
      scan_s2_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      scan_s1_q <= scan_s1_d;
      scan_s2_q <= scan_s2_d;
      presc_q   <= presc_d;
    end
  end
`else
  logic unused_scan;
  localparam int unused_scan_div = SCAN_DIV;
  assign unused_scan = scan_i;

  always_comb begin
    sel_d = sel_q;
    if (ena) begin
      sel_d = sel_step(sel_q, up_rise, dn_rise);
    end
  end
`endif

  always_comb begin
    en_s1_d = en_i;
    en_s2_d = en_s1_q;
    step_d  = (sel_d != sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      step_q  <= 1'b0;
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      step_q  <= step_d;
      en_s1_q <= en_s1_d;
      en_s2_q <= en_s2_d;
    end
  end

  assign sel_o  = sel_q;
  assign en_o   = en_s2_q;
  assign step_o = step_q;

endmodule
